// File: rtl/max7219_pkg.sv
// Shared definitions for the MAX7219 matrix back-end.
// Contents: register addresses, shifter state encoding, word-index layout
// (0..4 init words, 5..12 digit words), and small word/row helpers.
package max7219_pkg;

  // MAX7219 register addresses
  localparam logic [7:0] ADDR_NOOP     = 8'h00;
  localparam logic [7:0] ADDR_DIGIT0   = 8'h01;
  localparam logic [7:0] ADDR_DECODE   = 8'h09;
  localparam logic [7:0] ADDR_INTENS   = 8'h0A;
  localparam logic [7:0] ADDR_SCANLIM  = 8'h0B;
  localparam logic [7:0] ADDR_SHUTDN   = 8'h0C;
  localparam logic [7:0] ADDR_DISPTEST = 8'h0F;

  localparam int INIT_WORDS = 5;
  localparam int DIGITS     = 8;

  // Word-index layout of the sequencer
  localparam logic [3:0] IDX_LAST_INIT   = 4'(INIT_WORDS - 1);
  localparam logic [3:0] IDX_FIRST_DIGIT = 4'(INIT_WORDS);
  localparam logic [3:0] IDX_LAST_DIGIT  = 4'(INIT_WORDS + DIGITS - 1);

  // Word shifter state encoding
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_LOW  = 3'd2;
  localparam logic [2:0] ST_HIGH = 3'd3;
  localparam logic [2:0] ST_TAIL = 3'd4;
  localparam logic [2:0] ST_GAP  = 3'd5;

  // Power-up configuration word for init index 0..4
  function automatic logic [15:0] init_word(input logic [3:0] idx, input logic [3:0] intensity);
    logic [15:0] w;
    case (idx)
      4'd0:    w = {ADDR_SHUTDN, 8'h01};
      4'd1:    w = {ADDR_DECODE, 8'h00};
      4'd2:    w = {ADDR_INTENS, 4'h0, intensity};
      4'd3:    w = {ADDR_SCANLIM, 8'h07};
      4'd4:    w = {ADDR_DISPTEST, 8'h00};
      default: w = {ADDR_NOOP, 8'h00};
    endcase
    return w;
  endfunction

  // Refresh loops over the digit words forever once init is done
  function automatic logic [3:0] next_idx(input logic [3:0] idx);
    return (idx == IDX_LAST_DIGIT) ? IDX_FIRST_DIGIT : idx + 4'd1;
  endfunction

  // A blanked frame is sent as all-zero rows
  function automatic logic [7:0] mask_row(input logic [7:0] row, input logic blank);
    return blank ? 8'h00 : row;
  endfunction

endpackage

// File: rtl/max7219_word_shifter.sv
// Shifts one 16-bit word MSB-first over the MAX7219 3-wire link.
// Ports: clk, rst (async, active-high); start/word in (taken only when idle);
// word_end = last TAIL cycle (NCS rises next edge); done = last GAP cycle;
// din/ncs/sclk = registered link pins.
module max7219_word_shifter
  import max7219_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned CS_GAP  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] word,
  output logic        word_end,
  output logic        done,
  output logic        din,
  output logic        ncs,
  output logic        sclk
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LAST = 8'(CS_GAP - 1);

  logic [2:0]  state_r;
  logic [7:0]  div_cnt_r;
  logic [3:0]  bit_cnt_r;
  logic [15:0] shift_r;
  logic        div_zero_s;
  logic        take_s;

  assign div_zero_s = (div_cnt_r == 8'd0);
  assign word_end   = (state_r == ST_TAIL) && div_zero_s;
  assign done       = (state_r == ST_GAP) && div_zero_s;
  // The final GAP cycle counts as passing through IDLE, so back-to-back
  // words go GAP -> LOAD without an extra idle cycle.
  assign take_s     = start && ((state_r == ST_IDLE) || done);

  // Word shifter FSM: phase timing, bit shifting and link pins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      div_cnt_r <= 8'd0;
      bit_cnt_r <= 4'd0;
      shift_r   <= 16'h0000;
      din       <= 1'b0;
      ncs       <= 1'b1;
      sclk      <= 1'b0;
    end else if (take_s) begin
      state_r   <= ST_LOAD;
      shift_r   <= word;
      bit_cnt_r <= 4'd15;
      din       <= word[15];
      ncs       <= 1'b0;
      sclk      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: state_r <= ST_IDLE;
        ST_LOAD: begin
          state_r   <= ST_LOW;
          div_cnt_r <= DIV_LAST;
        end
        ST_LOW: begin
          if (div_zero_s) begin
            state_r   <= ST_HIGH;
            div_cnt_r <= DIV_LAST;
            sclk      <= 1'b1;
          end else begin
            div_cnt_r <= div_cnt_r - 8'd1;
          end
        end
        ST_HIGH: begin
          if (div_zero_s) begin
            sclk      <= 1'b0;
            div_cnt_r <= DIV_LAST;
            if (bit_cnt_r == 4'd0) begin
              state_r <= ST_TAIL;
            end else begin
              // Next bit goes out on the first cycle of the LOW phase only
              state_r   <= ST_LOW;
              bit_cnt_r <= bit_cnt_r - 4'd1;
              shift_r   <= {shift_r[14:0], 1'b0};
              din       <= shift_r[14];
            end
          end else begin
            div_cnt_r <= div_cnt_r - 8'd1;
          end
        end
        ST_TAIL: begin
          if (div_zero_s) begin
            state_r   <= ST_GAP;
            div_cnt_r <= GAP_LAST;
            ncs       <= 1'b1;
            din       <= 1'b0;
          end else begin
            div_cnt_r <= div_cnt_r - 8'd1;
          end
        end
        ST_GAP: begin
          if (div_zero_s) begin
            state_r <= ST_IDLE;
          end else begin
            div_cnt_r <= div_cnt_r - 8'd1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          din     <= 1'b0;
          ncs     <= 1'b1;
          sclk    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/max7219_matrix_driver.sv
// MAX7219 serial back-end for the 8x8 LED matrix: sends the init sequence
// once, then refreshes digits 1..8 from FILA0..FILA7 forever.
// Ports: CLOCK_50, RESET_InHigh (async); BLANK, FILA0..7 row data;
// DIN/NCS/CLK link pins; INIT_DONE level; FRAME_DONE 1-cycle pulse.
module max7219_matrix_driver
  import max7219_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned CS_GAP    = 2,
  parameter logic [3:0]  INTENSITY = 4'h8
) (
  input  logic       SC_MAX7219_CLOCK_50,
  input  logic       SC_MAX7219_RESET_InHigh,
  input  logic       SC_MAX7219_BLANK_InHigh,
  input  logic [7:0] SC_MAX7219_FILA0,
  input  logic [7:0] SC_MAX7219_FILA1,
  input  logic [7:0] SC_MAX7219_FILA2,
  input  logic [7:0] SC_MAX7219_FILA3,
  input  logic [7:0] SC_MAX7219_FILA4,
  input  logic [7:0] SC_MAX7219_FILA5,
  input  logic [7:0] SC_MAX7219_FILA6,
  input  logic [7:0] SC_MAX7219_FILA7,
  output logic       SC_MAX7219_DIN_Out,
  output logic       SC_MAX7219_NCS_Out,
  output logic       SC_MAX7219_CLK_Out,
  output logic       SC_MAX7219_INIT_DONE_Out,
  output logic       SC_MAX7219_FRAME_DONE_Out
);

  logic        clk;
  logic        rst;
  logic [3:0]  idx_r;
  logic [7:0]  rows_r [0:DIGITS-1];
  logic [7:0]  live_rows_s [0:DIGITS-1];
  logic [2:0]  digit_sel_s;
  logic [15:0] word_s;
  logic        word_end_s;
  logic        done_s;

  assign clk = SC_MAX7219_CLOCK_50;
  assign rst = SC_MAX7219_RESET_InHigh;

  // Current rows with blanking already applied
  always_comb begin
    live_rows_s[0] = mask_row(SC_MAX7219_FILA0, SC_MAX7219_BLANK_InHigh);
    live_rows_s[1] = mask_row(SC_MAX7219_FILA1, SC_MAX7219_BLANK_InHigh);
    live_rows_s[2] = mask_row(SC_MAX7219_FILA2, SC_MAX7219_BLANK_InHigh);
    live_rows_s[3] = mask_row(SC_MAX7219_FILA3, SC_MAX7219_BLANK_InHigh);
    live_rows_s[4] = mask_row(SC_MAX7219_FILA4, SC_MAX7219_BLANK_InHigh);
    live_rows_s[5] = mask_row(SC_MAX7219_FILA5, SC_MAX7219_BLANK_InHigh);
    live_rows_s[6] = mask_row(SC_MAX7219_FILA6, SC_MAX7219_BLANK_InHigh);
    live_rows_s[7] = mask_row(SC_MAX7219_FILA7, SC_MAX7219_BLANK_InHigh);
  end

  // Word selection: init table, then digit words. Digit 1 is loaded in the
  // same cycle as the snapshot, so it reads the live row directly.
  always_comb begin
    digit_sel_s = 3'(idx_r - IDX_FIRST_DIGIT);
    word_s      = 16'h0000;
    if (idx_r < IDX_FIRST_DIGIT) begin
      word_s = init_word(idx_r, INTENSITY);
    end else if (idx_r == IDX_FIRST_DIGIT) begin
      word_s = {ADDR_DIGIT0, live_rows_s[0]};
    end else begin
      word_s = {ADDR_DIGIT0 + {5'd0, digit_sel_s}, rows_r[digit_sel_s]};
    end
  end

  // Frame buffer: captured exactly when the digit-1 word is loaded
  // (start is tied high, so done always coincides with a load).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DIGITS; i++) rows_r[i] <= 8'h00;
    end else if (done_s && (idx_r == IDX_FIRST_DIGIT)) begin
      for (int i = 0; i < DIGITS; i++) rows_r[i] <= live_rows_s[i];
    end
  end

  // Word sequencer: step to the next word while the current one is in its gap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_r <= 4'd0;
    end else if (word_end_s) begin
      idx_r <= next_idx(idx_r);
    end
  end

  // Status flags, registered on the same edge that raises NCS
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      SC_MAX7219_INIT_DONE_Out  <= 1'b0;
      SC_MAX7219_FRAME_DONE_Out <= 1'b0;
    end else begin
      SC_MAX7219_FRAME_DONE_Out <= word_end_s && (idx_r == IDX_LAST_DIGIT);
      if (word_end_s && (idx_r == IDX_LAST_INIT)) begin
        SC_MAX7219_INIT_DONE_Out <= 1'b1;
      end
    end
  end

  max7219_word_shifter #(
    .CLK_DIV (CLK_DIV),
    .CS_GAP  (CS_GAP)
  ) u_shifter (
    .clk      (clk),
    .rst      (rst),
    .start    (1'b1),
    .word     (word_s),
    .word_end (word_end_s),
    .done     (done_s),
    .din      (SC_MAX7219_DIN_Out),
    .ncs      (SC_MAX7219_NCS_Out),
    .sclk     (SC_MAX7219_CLK_Out)
  );

endmodule
